branch_rs: RTL and testbench

BRANCH_RS -- requirements
Module: branch_rs

---
 rtl/branch_rs.sv | 217 +++++++++++++++++++++
 tb/tb_branch_rs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_rs.sv
// Branch reservation station: age-ordered queue of pending branches that snoops
// the CDB for operands and issues the oldest ready entry to the branch unit.
module branch_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 5,
    parameter int OP_W  = 6,
    parameter logic [TAG_W-1:0] UNLOCKED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    input  logic             alloc_en,
    input  logic [31:0]      alloc_pc,
    input  logic [31:0]      alloc_offset,
    input  logic [OP_W-1:0]  alloc_op,
    input  logic [TAG_W-1:0] alloc_tagx,
    input  logic [TAG_W-1:0] alloc_tagy,
    input  logic [31:0]      alloc_datax,
    input  logic [31:0]      alloc_datay,
    input  logic             cdb_en,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             full_out,
    output logic             branch_busy_out,
    output logic [31:0]      pc_out,
    output logic [31:0]      offset_out,
    output logic [OP_W-1:0]  op_out,
    output logic [TAG_W-1:0] tagx_out,
    output logic [TAG_W-1:0] tagy_out,
    output logic [31:0]      datax_out,
    output logic [31:0]      datay_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]    count;
    logic             e_valid [DEPTH];
    logic [31:0]      e_pc    [DEPTH];
    logic [31:0]      e_off   [DEPTH];
    logic [OP_W-1:0]  e_op    [DEPTH];
    logic [TAG_W-1:0] e_tagx  [DEPTH];
    logic [TAG_W-1:0] e_tagy  [DEPTH];
    logic [31:0]      e_datax [DEPTH];
    logic [31:0]      e_datay [DEPTH];

    // Post-snoop view; slot DEPTH is a permanently empty filler for the shift.
    logic             s_valid [DEPTH+1];
    logic [31:0]      s_pc    [DEPTH+1];
    logic [31:0]      s_off   [DEPTH+1];
    logic [OP_W-1:0]  s_op    [DEPTH+1];
    logic [TAG_W-1:0] s_tagx  [DEPTH+1];
    logic [TAG_W-1:0] s_tagy  [DEPTH+1];
    logic [31:0]      s_datax [DEPTH+1];
    logic [31:0]      s_datay [DEPTH+1];

    logic             n_valid [DEPTH];
    logic [31:0]      n_pc    [DEPTH];
    logic [31:0]      n_off   [DEPTH];
    logic [OP_W-1:0]  n_op    [DEPTH];
    logic [TAG_W-1:0] n_tagx  [DEPTH];
    logic [TAG_W-1:0] n_tagy  [DEPTH];
    logic [31:0]      n_datax [DEPTH];
    logic [31:0]      n_datay [DEPTH];

    logic             issue;
    int               sel;
    logic [31:0]      sel_pc, sel_off, sel_datax, sel_datay;
    logic [OP_W-1:0]  sel_op;
    logic             accept;
    logic             cdb_hit;
    logic [CW-1:0]    wr_idx;
    logic [CW-1:0]    n_count;

    assign full_out = (count == CW'(DEPTH));
    assign accept   = alloc_en && !full_out;
    assign cdb_hit  = cdb_en && (cdb_tag != UNLOCKED);
    assign wr_idx   = count - CW'(issue);
    assign n_count  = count + CW'(accept) - CW'(issue);

    // Readiness looks only at registered tags, so a capture issues a cycle later.
    always_comb begin
        issue     = 1'b0;
        sel       = 0;
        sel_pc    = '0;
        sel_off   = '0;
        sel_op    = '0;
        sel_datax = '0;
        sel_datay = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!issue && e_valid[i] && e_tagx[i] == UNLOCKED && e_tagy[i] == UNLOCKED) begin
                issue     = 1'b1;
                sel       = i;
                sel_pc    = e_pc[i];
                sel_off   = e_off[i];
                sel_op    = e_op[i];
                sel_datax = e_datax[i];
                sel_datay = e_datay[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i <= DEPTH; i++) begin
            s_valid[i] = 1'b0;
            s_pc[i]    = '0;
            s_off[i]   = '0;
            s_op[i]    = '0;
            s_tagx[i]  = UNLOCKED;
            s_tagy[i]  = UNLOCKED;
            s_datax[i] = '0;
            s_datay[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            s_valid[i] = e_valid[i];
            s_pc[i]    = e_pc[i];
            s_off[i]   = e_off[i];
            s_op[i]    = e_op[i];
            s_tagx[i]  = e_tagx[i];
            s_tagy[i]  = e_tagy[i];
            s_datax[i] = e_datax[i];
            s_datay[i] = e_datay[i];
            if (cdb_hit && e_valid[i] && e_tagx[i] == cdb_tag) begin
                s_tagx[i]  = UNLOCKED;
                s_datax[i] = cdb_data;
            end
            if (cdb_hit && e_valid[i] && e_tagy[i] == cdb_tag) begin
                s_tagy[i]  = UNLOCKED;
                s_datay[i] = cdb_data;
            end
        end
    end

    // Shift the snooped view down past the issued slot, then drop the new entry in.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && i >= sel) begin
                n_valid[i] = s_valid[i+1];
                n_pc[i]    = s_pc[i+1];
                n_off[i]   = s_off[i+1];
                n_op[i]    = s_op[i+1];
                n_tagx[i]  = s_tagx[i+1];
                n_tagy[i]  = s_tagy[i+1];
                n_datax[i] = s_datax[i+1];
                n_datay[i] = s_datay[i+1];
            end else begin
                n_valid[i] = s_valid[i];
                n_pc[i]    = s_pc[i];
                n_off[i]   = s_off[i];
                n_op[i]    = s_op[i];
                n_tagx[i]  = s_tagx[i];
                n_tagy[i]  = s_tagy[i];
                n_datax[i] = s_datax[i];
                n_datay[i] = s_datay[i];
            end
            if (accept && CW'(i) == wr_idx) begin
                n_valid[i] = 1'b1;
                n_pc[i]    = alloc_pc;
                n_off[i]   = alloc_offset;
                n_op[i]    = alloc_op;
                n_tagx[i]  = (cdb_hit && alloc_tagx == cdb_tag) ? UNLOCKED : alloc_tagx;
                n_datax[i] = (cdb_hit && alloc_tagx == cdb_tag) ? cdb_data : alloc_datax;
                n_tagy[i]  = (cdb_hit && alloc_tagy == cdb_tag) ? UNLOCKED : alloc_tagy;
                n_datay[i] = (cdb_hit && alloc_tagy == cdb_tag) ? cdb_data : alloc_datay;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count           <= '0;
            branch_busy_out <= 1'b0;
            pc_out          <= '0;
            offset_out      <= '0;
            op_out          <= '0;
            tagx_out        <= UNLOCKED;
            tagy_out        <= UNLOCKED;
            datax_out       <= '0;
            datay_out       <= '0;
            for (int i = 0; i < DEPTH; i++) e_valid[i] <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                count           <= '0;
                branch_busy_out <= 1'b0;
                pc_out          <= '0;
                offset_out      <= '0;
                op_out          <= '0;
                tagx_out        <= '0;
                tagy_out        <= '0;
                datax_out       <= '0;
                datay_out       <= '0;
                for (int i = 0; i < DEPTH; i++) e_valid[i] <= 1'b0;
            end else begin
                count           <= n_count;
                branch_busy_out <= issue;
                pc_out          <= issue ? sel_pc : '0;
                offset_out      <= issue ? sel_off : '0;
                op_out          <= issue ? sel_op : '0;
                tagx_out        <= issue ? UNLOCKED : '0;
                tagy_out        <= issue ? UNLOCKED : '0;
                datax_out       <= issue ? sel_datax : '0;
                datay_out       <= issue ? sel_datay : '0;
                for (int i = 0; i < DEPTH; i++) begin
                    e_valid[i] <= n_valid[i];
                    e_pc[i]    <= n_pc[i];
                    e_off[i]   <= n_off[i];
                    e_op[i]    <= n_op[i];
                    e_tagx[i]  <= n_tagx[i];
                    e_tagy[i]  <= n_tagy[i];
                    e_datax[i] <= n_datax[i];
                    e_datay[i] <= n_datay[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Directed bench for branch_rs: each task drives one scenario and checks the
// issue port against hand-computed values.
module tb_branch_rs;

    localparam logic [5:0] OP_BEQ = 6'h01;
    localparam logic [5:0] OP_BNE = 6'h02;
    localparam logic [5:0] OP_BLT = 6'h03;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, alloc_en, cdb_en;
    logic [31:0] alloc_pc, alloc_offset, alloc_datax, alloc_datay, cdb_data;
    logic [5:0]  alloc_op;
    logic [4:0]  alloc_tagx, alloc_tagy, cdb_tag;
    logic        full_out, branch_busy_out;
    logic [31:0] pc_out, offset_out, datax_out, datay_out;
    logic [5:0]  op_out;
    logic [4:0]  tagx_out, tagy_out;

    int total = 0;
    int bad   = 0;

    branch_rs dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_en(alloc_en), .alloc_pc(alloc_pc), .alloc_offset(alloc_offset),
        .alloc_op(alloc_op), .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
        .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .full_out(full_out), .branch_busy_out(branch_busy_out),
        .pc_out(pc_out), .offset_out(offset_out), .op_out(op_out),
        .tagx_out(tagx_out), .tagy_out(tagy_out),
        .datax_out(datax_out), .datay_out(datay_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_en = 1'b0;
        cdb_en   = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic drive_alloc(input logic [31:0] pc, input logic [31:0] off, input logic [5:0] op,
                               input logic [4:0] tx, input logic [4:0] ty,
                               input logic [31:0] dx, input logic [31:0] dy);
        alloc_en     = 1'b1;
        alloc_pc     = pc;
        alloc_offset = off;
        alloc_op     = op;
        alloc_tagx   = tx;
        alloc_tagy   = ty;
        alloc_datax  = dx;
        alloc_datay  = dy;
    endtask

    task automatic drive_cdb(input logic [4:0] tag, input logic [31:0] data);
        cdb_en   = 1'b1;
        cdb_tag  = tag;
        cdb_data = data;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; idle();
        tick(); tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", branch_busy_out); end
        total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%0h exp=0", pc_out); end
        total++; if (tagx_out !== 5'd0 || tagy_out !== 5'd0) begin bad++; $display("FAIL reset_tags got=%0h/%0h exp=0/0", tagx_out, tagy_out); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", dut.count); end
        rst = 1'b0;
        tick();
        total++; if (full_out !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", full_out); end
    endtask

    task automatic test_ready_alloc();
        drive_alloc(32'h100, 32'h20, OP_BEQ, 5'd0, 5'd0, 32'h11, 32'h22);
        tick(); idle();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL ready_early got=%0h exp=0", branch_busy_out); end
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h100 || offset_out !== 32'h20)
            begin bad++; $display("FAIL ready_issue busy=%0h pc=%0h off=%0h exp 1/100/20", branch_busy_out, pc_out, offset_out); end
        total++; if (op_out !== OP_BEQ || datax_out !== 32'h11 || datay_out !== 32'h22)
            begin bad++; $display("FAIL ready_fields op=%0h dx=%0h dy=%0h exp 1/11/22", op_out, datax_out, datay_out); end
        tick();
        total++; if (branch_busy_out !== 1'b0 || pc_out !== 32'h0)
            begin bad++; $display("FAIL ready_after busy=%0h pc=%0h exp 0/0", branch_busy_out, pc_out); end
    endtask

    task automatic test_cdb_wait();
        drive_alloc(32'h200, 32'h8, OP_BNE, 5'd3, 5'd0, 32'h0, 32'h5);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL wait_no_issue got=%0h exp=0", branch_busy_out); end
        drive_cdb(5'd4, 32'h77);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL wait_wrong_tag got=%0h exp=0", branch_busy_out); end
        drive_cdb(5'd3, 32'h55);
        tick(); idle();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL wait_capture_edge got=%0h exp=0", branch_busy_out); end
        tick();
        total++; if (branch_busy_out !== 1'b1 || datax_out !== 32'h55 || pc_out !== 32'h200)
            begin bad++; $display("FAIL wait_issue busy=%0h dx=%0h pc=%0h exp 1/55/200", branch_busy_out, datax_out, pc_out); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL wait_count got=%0d exp=0", dut.count); end
    endtask

    task automatic test_out_of_order();
        drive_alloc(32'h300, 32'h4, OP_BLT, 5'd2, 5'd0, 32'h0, 32'h1);
        tick();
        drive_alloc(32'h304, 32'h4, OP_BEQ, 5'd0, 5'd0, 32'h2, 32'h3);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h304)
            begin bad++; $display("FAIL ooo_b_first busy=%0h pc=%0h exp 1/304", branch_busy_out, pc_out); end
        total++; if (dut.count !== 3'd1) begin bad++; $display("FAIL ooo_count1 got=%0d exp=1", dut.count); end
        tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL ooo_gap got=%0h exp=0", branch_busy_out); end
        drive_cdb(5'd2, 32'h66);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h300 || datax_out !== 32'h66 || op_out !== OP_BLT)
            begin bad++; $display("FAIL ooo_a_issue busy=%0h pc=%0h dx=%0h op=%0h exp 1/300/66/3", branch_busy_out, pc_out, datax_out, op_out); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL ooo_count0 got=%0d exp=0", dut.count); end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            drive_alloc(32'h400 + 32'(4 * i), 32'h0, OP_BNE, 5'(5 + i), 5'd0, 32'h0, 32'h0);
            tick();
        end
        total++; if (full_out !== 1'b1 || dut.count !== 3'd4)
            begin bad++; $display("FAIL full_set full=%0h count=%0d exp 1/4", full_out, dut.count); end
        drive_alloc(32'h4F0, 32'h0, OP_BNE, 5'd5, 5'd0, 32'h0, 32'h0);
        tick(); idle();
        total++; if (dut.count !== 3'd4) begin bad++; $display("FAIL full_ignore count=%0d exp=4", dut.count); end
        drive_cdb(5'd6, 32'hAA);
        tick(); idle();
        total++; if (full_out !== 1'b1) begin bad++; $display("FAIL full_still got=%0h exp=1", full_out); end
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h404 || datax_out !== 32'hAA)
            begin bad++; $display("FAIL full_issue busy=%0h pc=%0h dx=%0h exp 1/404/aa", branch_busy_out, pc_out, datax_out); end
        total++; if (full_out !== 1'b0 || dut.count !== 3'd3)
            begin bad++; $display("FAIL full_fall full=%0h count=%0d exp 0/3", full_out, dut.count); end
        drive_alloc(32'h410, 32'h0, OP_BNE, 5'd9, 5'd0, 32'h0, 32'h0);
        tick(); idle();
        total++; if (full_out !== 1'b1 || dut.count !== 3'd4)
            begin bad++; $display("FAIL full_refill full=%0h count=%0d exp 1/4", full_out, dut.count); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick(); idle();
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL flush_clear count=%0d exp=0", dut.count); end
        for (int i = 0; i < 3; i++) begin
            drive_alloc(32'h580 + 32'(4 * i), 32'h0, OP_BEQ, 5'(10 + i), 5'd0, 32'h0, 32'h0);
            tick();
        end
        total++; if (dut.count !== 3'd3) begin bad++; $display("FAIL flush_three count=%0d exp=3", dut.count); end
        drive_alloc(32'h5A0, 32'h0, OP_BEQ, 5'd0, 5'd0, 32'h0, 32'h0);
        flush = 1'b1;
        tick(); idle();
        total++; if (dut.count !== 3'd0 || branch_busy_out !== 1'b0 || full_out !== 1'b0)
            begin bad++; $display("FAIL flush_apply count=%0d busy=%0h full=%0h exp 0/0/0", dut.count, branch_busy_out, full_out); end
        drive_cdb(5'd10, 32'h1);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL flush_no_issue got=%0h exp=0", branch_busy_out); end
        tick();
        total++; if (branch_busy_out !== 1'b0 || dut.count !== 3'd0)
            begin bad++; $display("FAIL flush_quiet busy=%0h count=%0d exp 0/0", branch_busy_out, dut.count); end
    endtask

    task automatic test_bypass();
        drive_alloc(32'h500, 32'hC, OP_BEQ, 5'd0, 5'd7, 32'h1, 32'h0);
        drive_cdb(5'd7, 32'h9);
        tick(); idle();
        tick();
        total++; if (branch_busy_out !== 1'b1 || datay_out !== 32'h9 || pc_out !== 32'h500 || datax_out !== 32'h1)
            begin bad++; $display("FAIL bypass busy=%0h dy=%0h pc=%0h dx=%0h exp 1/9/500/1", branch_busy_out, datay_out, pc_out, datax_out); end
    endtask

    task automatic test_snoop_shift();
        drive_alloc(32'h600, 32'h0, OP_BNE, 5'd14, 5'd0, 32'h0, 32'h0);
        tick();
        drive_alloc(32'h604, 32'h0, OP_BNE, 5'd13, 5'd0, 32'h0, 32'h0);
        tick(); idle();
        drive_cdb(5'd14, 32'h14);
        tick();
        drive_cdb(5'd13, 32'h31);
        tick(); idle();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h600 || datax_out !== 32'h14)
            begin bad++; $display("FAIL shift_first busy=%0h pc=%0h dx=%0h exp 1/600/14", branch_busy_out, pc_out, datax_out); end
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h604 || datax_out !== 32'h31)
            begin bad++; $display("FAIL shift_second busy=%0h pc=%0h dx=%0h exp 1/604/31", branch_busy_out, pc_out, datax_out); end
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL shift_count got=%0d exp=0", dut.count); end
    endtask

    task automatic test_reset_mid();
        drive_alloc(32'h700, 32'h10, OP_BLT, 5'd0, 5'd0, 32'h3, 32'h4);
        tick();
        drive_alloc(32'h704, 32'h10, OP_BLT, 5'd15, 5'd0, 32'h0, 32'h0);
        tick();
        total++; if (branch_busy_out !== 1'b1 || pc_out !== 32'h700)
            begin bad++; $display("FAIL mid_pre busy=%0h pc=%0h exp 1/700", branch_busy_out, pc_out); end
        rdy = 1'b0; rst = 1'b1;
        tick();
        total++; if (branch_busy_out !== 1'b0 || pc_out !== 32'h0 || offset_out !== 32'h0 || op_out !== 6'h0)
            begin bad++; $display("FAIL mid_rst_port busy=%0h pc=%0h off=%0h op=%0h exp 0/0/0/0", branch_busy_out, pc_out, offset_out, op_out); end
        total++; if (datax_out !== 32'h0 || datay_out !== 32'h0 || tagx_out !== 5'd0 || tagy_out !== 5'd0)
            begin bad++; $display("FAIL mid_rst_data dx=%0h dy=%0h tx=%0h ty=%0h exp 0/0/0/0", datax_out, datay_out, tagx_out, tagy_out); end
        total++; if (dut.count !== 3'd0 || full_out !== 1'b0)
            begin bad++; $display("FAIL mid_rst_count count=%0d full=%0h exp 0/0", dut.count, full_out); end
        rst = 1'b0;
        drive_alloc(32'h800, 32'h0, OP_BEQ, 5'd0, 5'd0, 32'h0, 32'h0);
        tick(); idle();
        total++; if (dut.count !== 3'd0) begin bad++; $display("FAIL hold_ignore count=%0d exp=0", dut.count); end
        rdy = 1'b1;
        tick(); tick();
        total++; if (branch_busy_out !== 1'b0) begin bad++; $display("FAIL hold_no_issue got=%0h exp=0", branch_busy_out); end
    endtask

    initial begin
        alloc_pc = '0; alloc_offset = '0; alloc_op = '0; alloc_tagx = '0; alloc_tagy = '0;
        alloc_datax = '0; alloc_datay = '0; cdb_tag = '0; cdb_data = '0;
        test_reset();
        test_ready_alloc();
        test_cdb_wait();
        test_out_of_order();
        test_full();
        test_flush();
        test_bypass();
        test_snoop_shift();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
